// File: rtl/processor_pkg.sv
// Shared encodings for the simple 32-bit processor: opcodes, branch conditions,
// status-register bit positions and the control-unit state type.
package processor_pkg;

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LD  = 4'h1;
   localparam logic [3:0] OP_STR = 4'h2;
   localparam logic [3:0] OP_BRA = 4'h3;
   localparam logic [3:0] OP_XOR = 4'h4;
   localparam logic [3:0] OP_ADD = 4'h5;
   localparam logic [3:0] OP_ROT = 4'h6;
   localparam logic [3:0] OP_SHF = 4'h7;
   localparam logic [3:0] OP_HLT = 4'h8;
   localparam logic [3:0] OP_CMP = 4'h9;

   localparam logic [3:0] CC_A  = 4'h0;
   localparam logic [3:0] CC_P  = 4'h1;
   localparam logic [3:0] CC_E  = 4'h2;
   localparam logic [3:0] CC_C  = 4'h3;
   localparam logic [3:0] CC_N  = 4'h4;
   localparam logic [3:0] CC_Z  = 4'h5;
   localparam logic [3:0] CC_NC = 4'h6;
   localparam logic [3:0] CC_NP = 4'h7;

   localparam int unsigned ST_C = 0;
   localparam int unsigned ST_P = 1;
   localparam int unsigned ST_E = 2;
   localparam int unsigned ST_N = 3;
   localparam int unsigned ST_Z = 4;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

endpackage

// File: rtl/processor_branch_eval.sv
// Branch condition evaluator: maps a condition code and the status flags to taken.
module processor_branch_eval
   import processor_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [4:0] status,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (cond)
         CC_A:    taken = 1'b1;
         CC_P:    taken = status[ST_P];
         CC_E:    taken = status[ST_E];
         CC_C:    taken = status[ST_C];
         CC_N:    taken = status[ST_N];
         CC_Z:    taken = status[ST_Z];
         CC_NC:   taken = ~status[ST_C];
         CC_NP:   taken = ~status[ST_P];
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/processor_control_unit.sv
// Multi-cycle sequencer: owns PC/IR, arbitrates the single memory port between
// fetch and LD/STR, and issues register-file, ALU and status strobes.
module processor_control_unit
   import processor_pkg::*;
#(
   parameter logic [11:0] RESET_PC = 12'h100,
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        mem_req,
   output logic        mem_we,
   output logic [11:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] ir,
   output logic [11:0] pc,
   input  logic [4:0]  status,
   output logic        rf_we,
   output logic        rf_wsel_mem,
   output logic [3:0]  alu_op,
   output logic        status_we,
   output logic        halted,
   output logic        fault
);

   localparam int unsigned WW = $clog2(MAX_WAIT + 1);

   state_t        state, state_n;
   logic [11:0]   pc_n;
   logic [31:0]   ir_n;
   logic          fault_n;
   logic [WW-1:0] wait_cnt;
   logic [31:0]   ldata;
   logic [3:0]    op;
   logic          taken;
   logic          timeout;

   assign op      = ir[31:28];
   assign timeout = !mem_ready && (wait_cnt == WW'(MAX_WAIT - 1));

   processor_branch_eval u_branch_eval (
      .cond   (ir[27:24]),
      .status (status),
      .taken  (taken)
   );

   always_comb begin
      state_n = state;
      pc_n    = pc;
      ir_n    = ir;
      fault_n = fault;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_n = S_FETCH;
               pc_n    = RESET_PC;
            end
         end
         S_FETCH: begin
            if (mem_ready) begin
               ir_n    = mem_rdata;
               pc_n    = pc + 12'd1;
               state_n = S_DECODE;
            end else if (timeout) begin
               fault_n = 1'b1;
               state_n = S_HALT;
            end
         end
         S_DECODE: begin
            case (op)
               OP_NOP:                                 state_n = S_FETCH;
               OP_HLT:                                 state_n = S_HALT;
               OP_LD, OP_STR:                          state_n = S_MEM;
               OP_XOR, OP_ADD, OP_ROT, OP_SHF, OP_CMP: state_n = S_EXEC;
               OP_BRA: begin
                  if (taken) pc_n = ir[11:0];
                  state_n = S_FETCH;
               end
               default: begin
                  fault_n = 1'b1;
                  state_n = S_HALT;
               end
            endcase
         end
         S_EXEC, S_WB: state_n = S_FETCH;
         S_MEM: begin
            if (mem_ready) begin
               state_n = (op == OP_LD) ? S_WB : S_FETCH;
            end else if (timeout) begin
               fault_n = 1'b1;
               state_n = S_HALT;
            end
         end
         S_HALT: begin
            if (start) begin
               state_n = S_FETCH;
               pc_n    = RESET_PC;
               fault_n = 1'b0;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         ir          <= '0;
         fault       <= 1'b0;
         wait_cnt    <= '0;
         ldata       <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         rf_we       <= 1'b0;
         rf_wsel_mem <= 1'b0;
         alu_op      <= '0;
         status_we   <= 1'b0;
         halted      <= 1'b0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         ir       <= ir_n;
         fault    <= fault_n;
         wait_cnt <= (state_n == state) ? wait_cnt + 1'b1 : '0;
         if (state == S_MEM && op == OP_LD && mem_ready) ldata <= mem_rdata;
         mem_req     <= (state_n == S_FETCH) || (state_n == S_MEM);
         mem_we      <= (state_n == S_MEM) && (op == OP_STR);
         mem_addr    <= (state_n == S_MEM) ? ((op == OP_STR) ? ir[11:0] : ir[23:12]) : pc_n;
         rf_we       <= ((state_n == S_EXEC) && (op != OP_CMP)) || (state_n == S_WB);
         rf_wsel_mem <= (state_n == S_WB);
         status_we   <= (state_n == S_EXEC) || (state_n == S_WB);
         alu_op      <= (state_n == S_EXEC) ? op : '0;
         halted      <= (state_n == S_HALT);
      end
   end

endmodule

// File: tb/tb_processor_control_unit.sv
// Bench for processor_control_unit: an instruction-level model expands each program
// into the expected per-cycle port trace, compared against the DUT every cycle.
module tb_processor_control_unit;

   localparam logic [11:0] RPC = 12'h100;
   localparam int          MW  = 16;

   logic        clk = 1'b0;
   logic        rst, start, mem_req, mem_we, mem_ready;
   logic        rf_we, rf_wsel_mem, status_we, halted, fault;
   logic [11:0] mem_addr, pc;
   logic [31:0] mem_rdata, ir;
   logic [4:0]  status;
   logic [3:0]  alu_op;

   always #5 clk = ~clk;

   processor_control_unit #(.RESET_PC(12'h100), .MAX_WAIT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ir(ir),
      .pc(pc), .status(status), .rf_we(rf_we), .rf_wsel_mem(rf_wsel_mem),
      .alu_op(alu_op), .status_we(status_we), .halted(halted), .fault(fault)
   );

   typedef struct packed {
      logic        req;
      logic        we;
      logic [11:0] addr;
      logic        rf_we;
      logic        wsel;
      logic [3:0]  alu_op;
      logic        swe;
      logic        halted;
      logic        fault;
      logic [11:0] pc;
      logic [31:0] ir;
   } obs_t;

   obs_t        exp_q[$], pend_q[$], act_log[$];
   int          lat_q[$], plan_q[$];
   logic [31:0] mem [0:4095];
   int          errors = 0, checks = 0;
   bit          rand_lat = 1'b0;
   logic [11:0] m_pc = 12'h100;
   logic [31:0] m_ir = '0;
   bit          in_acc = 1'b0;
   int          acc_cnt = 0, cur_lat = 0;

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic obs_t actual();
      obs_t o;
      o.req = mem_req;   o.we = mem_req ? mem_we : 1'b0;
      o.addr = mem_req ? mem_addr : 12'h000;
      o.rf_we = rf_we;   o.wsel = rf_wsel_mem; o.alu_op = alu_op;
      o.swe = status_we; o.halted = halted;    o.fault = fault;
      o.pc = pc;         o.ir = ir;
      return o;
   endfunction

   // ---------------- instruction-level reference model ----------------
   function automatic obs_t base();
      obs_t o = '0;
      o.pc = m_pc;
      o.ir = m_ir;
      return o;
   endfunction

   function automatic int next_lat();
      int r;
      if (plan_q.size() > 0) return plan_q.pop_front();
      if (!rand_lat) return 0;
      r = $urandom_range(0, 39);
      return (r == 0) ? 99 : r % 4;
   endfunction

   // One memory access: lat wait cycles then the ready cycle, or a timeout.
   function automatic bit access(input bit we, input logic [11:0] a);
      int   lat;
      obs_t o;
      lat = next_lat();
      lat_q.push_back(lat);
      o = base(); o.req = 1'b1; o.we = we; o.addr = a;
      if (lat >= MW) begin
         repeat (MW) pend_q.push_back(o);
         return 1'b0;
      end
      for (int k = 0; k <= lat; k++) pend_q.push_back(o);
      return 1'b1;
   endfunction

   function automatic void halt_recs(input bit f);
      obs_t o;
      o = base(); o.halted = 1'b1; o.fault = f;
      repeat (3) pend_q.push_back(o);
   endfunction

   function automatic bit cond_true(input logic [3:0] cc, input logic [4:0] s);
      case (cc)
         4'd0: return 1'b1;
         4'd1: return s[1];
         4'd2: return s[2];
         4'd3: return s[0];
         4'd4: return s[3];
         4'd5: return s[4];
         4'd6: return ~s[0];
         4'd7: return ~s[1];
         default: return 1'b0;
      endcase
   endfunction

   function automatic void model_run();
      obs_t       o;
      logic [3:0] op;
      m_pc = RPC;
      for (int n = 0; n < 500; n++) begin
         if (!access(1'b0, m_pc)) begin halt_recs(1'b1); return; end
         m_ir = mem[m_pc];
         m_pc = m_pc + 12'd1;
         pend_q.push_back(base());
         op = m_ir[31:28];
         case (op)
            4'h0: ;
            4'h8: begin halt_recs(1'b0); return; end
            4'h1: begin
               if (!access(1'b0, m_ir[23:12])) begin halt_recs(1'b1); return; end
               o = base(); o.rf_we = 1'b1; o.wsel = 1'b1; o.swe = 1'b1;
               pend_q.push_back(o);
            end
            4'h2: if (!access(1'b1, m_ir[11:0])) begin halt_recs(1'b1); return; end
            4'h3: if (cond_true(m_ir[27:24], status)) m_pc = m_ir[11:0];
            4'h4, 4'h5, 4'h6, 4'h7, 4'h9: begin
               o = base(); o.alu_op = op; o.rf_we = (op != 4'h9); o.swe = 1'b1;
               pend_q.push_back(o);
            end
            default: begin halt_recs(1'b1); return; end
         endcase
      end
   endfunction

   // ---------------- memory responder ----------------
   initial begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst || !mem_req) begin
            in_acc    = 1'b0;
            mem_ready = 1'b0;
         end else begin
            if (!in_acc) begin
               in_acc  = 1'b1;
               acc_cnt = 0;
               cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
            end else begin
               acc_cnt++;
            end
            if (acc_cnt == cur_lat) begin
               mem_ready = 1'b1;
               mem_rdata = mem[mem_addr];
               in_acc    = 1'b0;
            end else begin
               mem_ready = 1'b0;
               mem_rdata = $urandom;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      obs_t e, a;
      forever begin
         @(negedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = actual();
            act_log.push_back(a);
            chk($sformatf("cycle%0d", act_log.size() - 1), 80'(a), 80'(e));
         end
      end
   end

   task automatic run_prog();
      int budget;
      act_log.delete(); pend_q.delete(); lat_q.delete();
      @(negedge clk);
      start = 1'b1;
      model_run();
      @(negedge clk);
      start = 1'b0;
      exp_q = pend_q;
      budget = 0;
      while (exp_q.size() > 0 && budget < 4000) begin
         @(negedge clk); #2;
         budget++;
      end
      if (exp_q.size() > 0) begin
         checks++; errors++;
         $display("FAIL run_timeout: %0d cycles still pending, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic load2(input logic [31:0] w0, input logic [31:0] w1);
      mem[12'h100] = w0;
      mem[12'h101] = w1;
   endtask

   initial begin
      logic [31:0] w;
      int          len, r, rfw;
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      rst = 1'b1; start = 1'b0; status = '0;
      #2;
      chk("reset_req_halt_fault", {mem_req, halted, fault}, 3'b000);
      chk("reset_strobes", {rf_we, rf_wsel_mem, status_we, alu_op}, 7'h00);
      chk("reset_pc", pc, 12'h100);
      chk("reset_ir", ir, 32'h0);
      @(negedge clk); rst = 1'b0;

      // NOP @100, HLT @101
      load2(32'h0000_0000, 32'h8000_0000);
      run_prog();
      chk("nophlt_fetch0", act_log[0].addr, 12'h100);
      chk("nophlt_fetch1", act_log[2].addr, 12'h101);
      chk("nophlt_halt_c4", {act_log[3].halted, act_log[4].halted}, 2'b01);
      chk("nophlt_pc", pc, 12'h102);

      // ADD: one strobe cycle, next fetch 3 cycles after the first
      load2(32'h5001_0002, 32'h8000_0000);
      run_prog();
      chk("add_exec", {act_log[2].rf_we, act_log[2].swe, act_log[2].alu_op}, 6'b11_0101);
      rfw = 0;
      foreach (act_log[i]) rfw += act_log[i].rf_we;
      chk("add_rfwe_count", rfw, 1);
      chk("add_next_fetch", {act_log[3].req, act_log[3].addr}, {1'b1, 12'h101});

      // LD: source address ir[23:12], WB selects memory data
      load2(32'h1005_0003, 32'h8000_0000);
      run_prog();
      chk("ld_mem", {act_log[2].req, act_log[2].we, act_log[2].addr}, {2'b10, 12'h050});
      chk("ld_wb", {act_log[3].rf_we, act_log[3].wsel, act_log[3].swe}, 3'b111);
      chk("ld_next_fetch", act_log[4].addr, 12'h101);

      // BRA on zero
      load2(32'h3500_0200, 32'h8000_0000);
      mem[12'h200] = 32'h8000_0000;
      status = 5'b10000;
      run_prog();
      chk("bra_z_taken", act_log[2].addr, 12'h200);
      status = 5'b01111;
      run_prog();
      chk("bra_z_not", act_log[2].addr, 12'h101);
      mem[12'h100] = 32'h3900_0200;
      status = 5'b11111;
      run_prog();
      chk("bra_cc9_never", act_log[2].addr, 12'h101);

      // STR with 3 wait cycles, then with no ready at all
      load2(32'h2000_0ABC, 32'h8000_0000);
      plan_q = '{0, 3};
      run_prog();
      for (int k = 2; k <= 5; k++)
         chk($sformatf("str_hold%0d", k), {act_log[k].req, act_log[k].we, act_log[k].addr}, {2'b11, 12'hABC});
      chk("str_next_fetch", act_log[6].addr, 12'h101);
      plan_q = '{0, 99};
      run_prog();
      chk("tmo_last_req", act_log[17].req, 1'b1);
      chk("tmo_halt_fault", {act_log[18].req, act_log[18].halted, act_log[18].fault}, 3'b011);

      // Illegal opcode, then restart from HALT
      mem[12'h100] = 32'hC000_0000;
      run_prog();
      chk("illegal_halt_fault", {act_log[2].halted, act_log[2].fault}, 2'b11);
      load2(32'h0000_0000, 32'h8000_0000);
      run_prog();
      chk("restart_fault_clr", {act_log[0].fault, act_log[0].addr}, {1'b0, 12'h100});

      // PC wrap from FFF
      mem[12'h100] = 32'h3000_0FFF;
      mem[12'hFFF] = 32'h0000_0000;
      mem[12'h000] = 32'h8000_0000;
      run_prog();
      chk("wrap_fetch_fff", act_log[2].addr, 12'hFFF);
      chk("wrap_pc0", act_log[3].pc, 12'h000);
      chk("wrap_fetch_000", act_log[4].addr, 12'h000);

      // Async reset in the middle of a stalled fetch
      mem[12'h100] = 32'h0000_0000;
      lat_q = '{99};
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk); @(negedge clk);
      #1 chk("rstmid_req_before", mem_req, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_req", mem_req, 1'b0);
      chk("rstmid_pc", pc, 12'h100);
      chk("rstmid_ir", ir, 32'h0);
      m_ir = '0;
      @(negedge clk); rst = 1'b0; lat_q.delete();
      repeat (3) @(negedge clk);
      #1 chk("rstmid_idle", {mem_req, halted}, 2'b00);

      // Randomised programs with random latencies and status
      rand_lat = 1'b1;
      for (int p = 0; p < 40; p++) begin
         status = 5'($urandom);
         len = $urandom_range(3, 12);
         for (int i = 0; i < len; i++) begin
            w = $urandom;
            if (i == len - 1) begin
               w = 32'h8000_0000;
            end else begin
               r = $urandom_range(0, 10);
               w[31:28] = (r < 10) ? 4'(r) : 4'($urandom_range(10, 15));
               if (w[31:28] == 4'h3) w[11:0] = RPC + 12'($urandom_range(i + 1, len - 1));
            end
            mem[RPC + 12'(i)] = w;
         end
         run_prog();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
